// File: rtl/axi_mem_master.sv
// Core-side request port to AXI4 AR/R and AW/W/B adapter.
// One INCR burst of up to 256 beats in flight; read and write data pass through combinationally.
module axi_mem_master #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // core request
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [7:0]              i_req_len,
    // core write data
    input  logic                    i_wd_valid,
    output logic                    o_wd_ready,
    input  logic [DATA_WIDTH-1:0]   i_wd_data,
    input  logic [DATA_WIDTH/8-1:0] i_wd_strb,
    // core read data
    output logic                    o_rd_valid,
    input  logic                    i_rd_ready,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_last,
    output logic                    o_rd_err,
    // core write completion
    output logic                    o_wr_done,
    output logic                    o_wr_err,
    // AXI AR
    output logic [ID_WIDTH-1:0]     o_arid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]              o_arlen,
    output logic [2:0]              o_arsize,
    output logic [1:0]              o_arburst,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    // AXI R
    input  logic [ID_WIDTH-1:0]     i_rid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    // AXI AW
    output logic [ID_WIDTH-1:0]     o_awid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    // AXI W
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    // AXI B
    input  logic [ID_WIDTH-1:0]     i_bid,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready
);

    localparam logic [2:0] AXSIZE  = 3'($clog2(DATA_WIDTH/8));
    localparam logic [1:0] INCR    = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [7:0]            r_len;
    logic [7:0]            w_len_next;
    logic [8:0]            r_cnt;
    logic [8:0]            w_cnt_next;
    logic                  w_at_last;
    logic                  w_unused_ids;

    // Only one burst is ever outstanding, so response IDs carry no information.
    assign w_unused_ids = ^{i_rid, i_bid};

    assign w_at_last = (r_cnt == {1'b0, r_len});

    assign o_arid    = ID_WIDTH'(AXI_ID);
    assign o_araddr  = r_addr;
    assign o_arlen   = r_len;
    assign o_arsize  = AXSIZE;
    assign o_arburst = INCR;
    assign o_awid    = ID_WIDTH'(AXI_ID);
    assign o_awaddr  = r_addr;
    assign o_awlen   = r_len;
    assign o_awsize  = AXSIZE;
    assign o_awburst = INCR;
    assign o_rd_data = i_rdata;
    assign o_wdata   = i_wd_data;
    assign o_wstrb   = i_wd_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_len   <= w_len_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_len_next   = r_len;
        w_cnt_next   = r_cnt;
        o_req_ready  = 1'b0;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_rd_valid   = 1'b0;
        o_rd_last    = 1'b0;
        o_rd_err     = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_wd_ready   = 1'b0;
        o_wlast      = 1'b0;
        o_bready     = 1'b0;
        o_wr_done    = 1'b0;
        o_wr_err     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_addr_next  = i_req_addr;
                    w_len_next   = i_req_len;
                    w_cnt_next   = '0;
                    w_state_next = i_req_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                o_arvalid = 1'b1;
                if (i_arready) w_state_next = S_R;
            end
            S_R: begin
                o_rready   = i_rd_ready;
                o_rd_valid = i_rvalid;
                o_rd_last  = w_at_last;
                // Our own beat count decides the end of the burst; RLAST only feeds the error flag.
                o_rd_err   = (i_rresp != 2'b00) | (i_rlast != w_at_last);
                if (i_rvalid && i_rd_ready) begin
                    w_cnt_next = r_cnt + 9'd1;
                    if (w_at_last) w_state_next = S_IDLE;
                end
            end
            S_AW: begin
                o_awvalid = 1'b1;
                if (i_awready) w_state_next = S_W;
            end
            S_W: begin
                o_wvalid   = i_wd_valid;
                o_wd_ready = i_wready;
                o_wlast    = w_at_last;
                if (i_wd_valid && i_wready) begin
                    w_cnt_next = r_cnt + 9'd1;
                    if (w_at_last) w_state_next = S_B;
                end
            end
            S_B: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    o_wr_done    = 1'b1;
                    o_wr_err     = (i_bresp != 2'b00);
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_master.sv
// Self-checking bench for axi_mem_master: directed scenarios plus randomized bursts
// against a beat-level model of the core and slave sides.
module tb_axi_mem_master;

    localparam int         IDW   = 4;
    localparam int         AW    = 16;
    localparam int         DW    = 32;
    localparam int         AXID  = 0;
    localparam logic [2:0] SIZE  = 3'd2;
    localparam logic [1:0] INCR  = 2'b01;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_req_valid, o_req_ready, i_req_write;
    logic [AW-1:0]   i_req_addr;
    logic [7:0]      i_req_len;
    logic            i_wd_valid, o_wd_ready;
    logic [DW-1:0]   i_wd_data;
    logic [DW/8-1:0] i_wd_strb;
    logic            o_rd_valid, i_rd_ready, o_rd_last, o_rd_err;
    logic [DW-1:0]   o_rd_data;
    logic            o_wr_done, o_wr_err;
    logic [IDW-1:0]  o_arid, o_awid, i_rid, i_bid;
    logic [AW-1:0]   o_araddr, o_awaddr;
    logic [7:0]      o_arlen, o_awlen;
    logic [2:0]      o_arsize, o_awsize;
    logic [1:0]      o_arburst, o_awburst;
    logic            o_arvalid, i_arready, o_awvalid, i_awready;
    logic [DW-1:0]   i_rdata, o_wdata;
    logic [1:0]      i_rresp, i_bresp;
    logic            i_rlast, i_rvalid, o_rready;
    logic [DW/8-1:0] o_wstrb;
    logic            o_wlast, o_wvalid, i_wready;
    logic            i_bvalid, o_bready;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [DW-1:0]   tx_data [256];
    logic [DW/8-1:0] tx_strb [256];
    logic [1:0]      tx_resp [256];

    always #5 clk = ~clk;

    axi_mem_master #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID(AXID)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_wd_valid(i_wd_valid), .o_wd_ready(o_wd_ready), .i_wd_data(i_wd_data), .i_wd_strb(i_wd_strb),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_rd_last(o_rd_last), .o_rd_err(o_rd_err),
        .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns just after the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_req(input logic wr, input logic [AW-1:0] addr, input int len);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_len   = 8'(len);
        #1 check_eq("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
        step();
        i_req_valid = 1'b0;
        i_req_addr  = 16'($urandom);
        i_req_len   = 8'($urandom);
    endtask

    // rdy_mode: 0 always ready, 1 toggle starting at 1, 2 random.
    task automatic do_read(input logic [AW-1:0] addr, input int len, input int rdy_mode,
                           input bit gaps, input int rlast_at, input bit drop_last);
        int  n, b, guard;
        bit  vld, rdy, tog, exp_err, lst;
        issue_req(1'b0, addr, len);
        n = gaps ? $urandom_range(0, 3) : 0;
        for (int k = 0; k <= n; k++) begin
            i_arready = (k == n);
            #1 check_eq("ar_channel", {30'd0, o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid},
                        {30'd0, 1'b1, addr, 8'(len), SIZE, INCR, 4'(AXID)});
            check_eq("ar_no_aw", {63'd0, o_awvalid}, 64'd0);
            step();
        end
        i_arready = 1'b0;
        b = 0; guard = 0; tog = 1'b1;
        while (b <= len) begin
            if (guard++ > 4000) begin
                check_eq("r_timeout", 64'd0, 64'd1);
                break;
            end
            vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'($urandom);
            lst = (b == rlast_at) || ((b == len) && !drop_last);
            i_rvalid   = vld;
            i_rdata    = vld ? tx_data[b] : $urandom;
            i_rresp    = vld ? tx_resp[b] : 2'($urandom);
            i_rlast    = vld ? lst : 1'($urandom);
            i_rid      = 4'($urandom);
            i_rd_ready = rdy;
            exp_err    = (tx_resp[b] != 2'b00) || (lst != (b == len));
            #1 check_eq("r_pass", {62'd0, o_rready, o_rd_valid}, {62'd0, rdy, vld});
            if (vld)
                check_eq("rd_beat", {29'd0, o_rd_data, o_rd_last, o_rd_err},
                         {29'd0, tx_data[b], (b == len), exp_err});
            if (vld && rdy) b++;
            tog = ~tog;
            step();
        end
        i_rvalid = 1'b0; i_rd_ready = 1'b0; i_rlast = 1'b0;
        #1 check_eq("r_to_idle", {61'd0, o_req_ready, o_arvalid, o_rready}, 64'd4);
        $display("read  addr=0x%04h len=%0d mode=%0d gaps=%0d rlast_at=%0d drop=%0d", addr, len,
                 rdy_mode, gaps, rlast_at, drop_last);
    endtask

    // abort_at >= 0 pulls rst_n low once that many beats have been written.
    task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [1:0] bresp,
                            input bit rnd, input int stall_beat, input int abort_at);
        int n, b, guard, stall;
        bit vld, rdy, hit;
        issue_req(1'b1, addr, len);
        n = rnd ? $urandom_range(0, 3) : 0;
        for (int k = 0; k <= n; k++) begin
            i_awready  = (k == n);
            i_wd_valid = 1'b1;
            i_wd_data  = tx_data[0];
            i_wd_strb  = tx_strb[0];
            i_wready   = 1'b1;
            #1 check_eq("aw_channel", {30'd0, o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awid},
                        {30'd0, 1'b1, addr, 8'(len), SIZE, INCR, 4'(AXID)});
            check_eq("w_before_aw", {62'd0, o_wvalid, o_wd_ready}, 64'd0);
            step();
        end
        i_awready = 1'b0;
        b = 0; guard = 0; stall = 0;
        while (b <= len) begin
            if (guard++ > 4000) begin
                check_eq("w_timeout", 64'd0, 64'd1);
                break;
            end
            if (b == abort_at) begin
                i_wd_valid = 1'b1; i_wready = 1'b1; i_wd_data = tx_data[b];
                #1 check_eq("pre_abort_wvalid", {63'd0, o_wvalid}, 64'd1);
                #2 rst_n = 1'b0;
                #1 check_eq("abort_outputs",
                            {57'd0, o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_wr_done, o_req_ready},
                            64'd1);
                i_wd_valid = 1'b0; i_wready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    #1 check_eq("abort_no_done", {63'd0, o_wr_done}, 64'd0);
                end
                rst_n = 1'b1;
                step();
                #1 check_eq("abort_idle", {61'd0, o_req_ready, o_awvalid, o_wvalid}, 64'd4);
                $display("write addr=0x%04h len=%0d aborted by reset after %0d beats", addr, len, b);
                return;
            end
            vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) begin
                rdy = 1'($urandom);
            end else begin
                rdy = !((b == stall_beat) && (stall < 2));
                if (!rdy) stall++;
            end
            i_wd_valid = vld;
            i_wd_data  = vld ? tx_data[b] : $urandom;
            i_wd_strb  = vld ? tx_strb[b] : 4'($urandom);
            i_wready   = rdy;
            #1 check_eq("w_pass", {62'd0, o_wvalid, o_wd_ready}, {62'd0, vld, rdy});
            if (vld)
                check_eq("w_beat", {27'd0, o_wdata, o_wstrb, o_wlast},
                         {27'd0, tx_data[b], tx_strb[b], (b == len)});
            if (vld && rdy) b++;
            step();
        end
        i_wd_valid = 1'b0; i_wready = 1'b0;
        n = rnd ? $urandom_range(0, 3) : 0;
        for (int k = 0; k <= n; k++) begin
            hit      = (k == n);
            i_bvalid = hit;
            i_bresp  = hit ? bresp : 2'($urandom);
            i_bid    = 4'($urandom);
            #1 check_eq("b_phase", {60'd0, o_bready, o_wr_done, o_wr_err, o_req_ready},
                        {60'd0, 1'b1, hit, hit && (bresp != 2'b00), 1'b0});
            step();
        end
        i_bvalid = 1'b0;
        #1 check_eq("b_to_idle", {62'd0, o_wr_done, o_req_ready}, 64'd1);
        $display("write addr=0x%04h len=%0d bresp=%0d rnd=%0d", addr, len, bresp, rnd);
    endtask

    task automatic fill_random(input int len, input bit with_err);
        for (int i = 0; i <= len; i++) begin
            tx_data[i] = $urandom;
            tx_strb[i] = 4'($urandom);
            tx_resp[i] = (with_err && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid = 0; i_req_write = 0; i_req_addr = '0; i_req_len = '0;
        i_wd_valid = 0; i_wd_data = '0; i_wd_strb = '0; i_rd_ready = 0;
        i_arready = 0; i_rid = '0; i_rdata = '0; i_rresp = '0; i_rlast = 0; i_rvalid = 0;
        i_awready = 0; i_wready = 0; i_bid = '0; i_bresp = '0; i_bvalid = 0;
        @(negedge clk);
        @(negedge clk);
        #1 check_eq("reset_state",
                    {56'd0, o_req_ready, o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_wr_done, o_rd_valid},
                    64'h80);
        check_eq("reset_addr_len", {40'd0, o_araddr, o_arlen}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tx_data[0] = 32'hDEADBEEF; tx_resp[0] = 2'b00;
        do_read(16'h0010, 0, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            tx_data[i] = 32'(i + 1);
            tx_resp[i] = 2'b00;
        end
        do_read(16'h0020, 3, 1, 1'b0, 3, 1'b0);

        for (int i = 0; i < 4; i++) begin
            tx_data[i] = 32'hA0 + 32'(i);
            tx_strb[i] = 4'hF;
        end
        do_write(16'h0100, 3, 2'b00, 1'b0, 1, -1);

        tx_data[0] = 32'h1234_5678; tx_strb[0] = 4'h3;
        do_write(16'h0200, 0, 2'b10, 1'b0, -1, -1);

        fill_random(3, 1'b0);
        do_read(16'h0300, 3, 0, 1'b0, 1, 1'b0);

        fill_random(3, 1'b0);
        do_read(16'h0340, 3, 0, 1'b0, 3, 1'b1);

        fill_random(3, 1'b0);
        do_write(16'h0400, 3, 2'b00, 1'b0, -1, 2);

        fill_random(255, 1'b0);
        do_read(16'h1000, 255, 0, 1'b0, 255, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int        len;
            logic [AW-1:0] addr;
            len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            addr = 16'($urandom) & 16'hFFFC;
            fill_random(len, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, len, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                         1'b1, -1, -1);
            end else begin
                do_read(addr, len, 2, 1'b1,
                        ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len,
                        ($urandom_range(0, 7) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/axi_mem_master.md
Name: axi_mem_master

Overview:
- Initiator-side AXI4 adapter: converts a simple core-side memory request port into AXI4 AR/R or AW/W/B transactions.
- Issues INCR bursts of up to 256 full-width beats, with one transaction outstanding at a time.
- Sits between a CPU core or cache refill logic and the AXI interconnect, whose targets include the RAM-side AXI slave bridge.
- Core sees ready/valid streams for request, write data, read data and write completion.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, data width; power of two, minimum 8.
- AXI_ID, 0, constant ID driven on ARID/AWID.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  start byte address, aligned to DATA_WIDTH/8
- req_len  in  8  beats minus one (AXI LEN encoding)
- wd_valid / wd_ready  in / out  1  write-data stream handshake
- wd_data  in  DATA_WIDTH  write beat data
- wd_strb  in  DATA_WIDTH/8  write beat byte enables
- rd_valid / rd_ready  out / in  1  read-data stream handshake
- rd_data  out  DATA_WIDTH  read beat data
- rd_last  out  1  final beat of the burst
- rd_err  out  1  RRESP!=OKAY, or RLAST/beat-count mismatch on this beat
- wr_done  out  1  one-cycle pulse when B is received
- wr_err  out  1  valid with wr_done; BRESP!=OKAY
- AR: ARID, ARADDR, ARLEN[8], ARSIZE[3], ARBURST[2], ARVALID out; ARREADY in
- R: RID, RDATA, RRESP[2], RLAST, RVALID in; RREADY out
- AW: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID out; AWREADY in
- W: WDATA, WSTRB, WLAST, WVALID out; WREADY in
- B: BID, BRESP[2], BVALID in; BREADY out

Behaviour:
- Reset (async, rst_n low): state IDLE; all VALID outputs and RREADY/BREADY 0; wr_done 0; beat counter 0; latched address/len 0.
- Reset mid-burst aborts immediately with no completion reported; the system resets the interconnect together with this block.
- Constant fields:
  - ARSIZE = AWSIZE = log2(DATA_WIDTH/8).
  - ARBURST = AWBURST = 2'b01 (INCR).
  - ARID = AWID = AXI_ID.
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE:
  - req_ready=1; all other handshake outputs 0.
  - On req_valid, latch addr, len and write; counter cleared.
  - Next state: AW if write, else AR. Request latency is 1 cycle to VALID assertion.
- AR:
  - ARVALID=1; ARADDR/ARLEN from latches, held stable until ARREADY.
  - On ARVALID&ARREADY -> R.
- R:
  - Pass-through, no buffering: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA.
  - rd_last = (count==len). rd_err = (RRESP!=0) | (RLAST != (count==len)).
  - Each RVALID&RREADY increments count.
  - The beat with count==len -> IDLE, regardless of RLAST; a mismatch there is flagged through rd_err.
  - An early RLAST (count<len) flags rd_err on that beat. The block stays in R for the remaining beats and does not hang.
- AW:
  - AWVALID=1 until AWREADY, then -> W.
  - W data never precedes AW.
- W:
  - Pass-through: WVALID=wd_valid, wd_ready=WREADY, WDATA=wd_data, WSTRB=wd_strb.
  - WLAST=(count==len).
  - Count increments on WVALID&WREADY; the last handshake -> B.
- B:
  - BREADY=1. On BVALID: wr_done=1 for that cycle, wr_err=(BRESP!=0), then -> IDLE.
  - BID and RID are ignored, since only one transaction is ever outstanding.
- Counter: 9 bits, so len=255 cannot wrap.
- Address wrap: not handled here; the slave owns address increment.
- req_ready is 0 in every non-IDLE state, so a new request cannot be accepted while the B pulse is active.
- The combinational pass-through paths (R→rd, wd→W) are deliberate; there are no registered data paths.

Test Plan:
- Read, addr=0x0010, len=0; slave returns RDATA=0xDEADBEEF, RLAST=1, OKAY.
  - Expect ARADDR=0x0010, ARLEN=0, ARSIZE=2, ARBURST=1.
  - Expect one rd beat with data 0xDEADBEEF, rd_last=1, rd_err=0; return to IDLE; req_ready=1 the next cycle.
- Read len=3 with rd_ready toggling 1,0,1,0; slave data 1,2,3,4.
  - Expect RREADY to mirror rd_ready, 4 beats in order, rd_last only on beat 4.
- Write addr=0x0100, len=3, data A..D, WSTRB=0xF; WREADY low for 2 cycles before beat 2.
  - Expect AWVALID before any WVALID, data held across the stall, WLAST only on D.
  - BRESP=OKAY → wr_done pulse, wr_err=0.
- Write len=0 with BRESP=2'b10 → wr_done=1, wr_err=1 for exactly one cycle.
- Read len=3 with slave asserting RLAST on beat 2 → rd_err=1 on beat 2. Block accepts beats 3 and 4, sets rd_last on beat 4, then reaches IDLE.
- rst_n low during W after 2 of 4 beats → all VALIDs 0 asynchronously, no wr_done; after release, IDLE with req_ready=1.
